// File: rtl/breath_led_ctrl.sv
// Breathing-LED sequencer: free-running PWM counter plus a rise/hold/fall/hold
// duty profile advanced by step strobes, applied only at PWM period boundaries.
module breath_led_ctrl #(
  parameter int PWM_W      = 8,
  parameter int STEP       = 1,
  parameter int HOLD_STEPS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_en,
  input  logic             s4_pulse,
  input  logic             mode,
  output logic             pwm_out,
  output logic [PWM_W-1:0] duty,
  output logic [1:0]       state,
  output logic             cycle_done
);

  localparam int HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

  localparam logic [PWM_W-1:0]  MAX_V     = '1;
  localparam logic [PWM_W-1:0]  STEP_V    = PWM_W'(STEP);
  localparam logic [PWM_W-1:0]  RISE_LIM  = MAX_V - STEP_V;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

  localparam logic [1:0] RISE    = 2'd0;
  localparam logic [1:0] HOLD_HI = 2'd1;
  localparam logic [1:0] FALL    = 2'd2;
  localparam logic [1:0] HOLD_LO = 2'd3;

  logic [PWM_W-1:0]  pwm_cnt_q,    pwm_cnt_d;
  logic [PWM_W-1:0]  duty_q,       duty_d;
  logic [1:0]        state_q,      state_d;
  logic [HOLD_W-1:0] hold_cnt_q,   hold_cnt_d;
  logic              pending_q,    pending_d;
  logic              pwm_out_q,    pwm_out_d;
  logic              cycle_done_q, cycle_done_d;

  logic boundary;

  assign boundary = (pwm_cnt_q == MAX_V);

  always_comb begin
    // NOTE: every variable gets a default first so no path through this block
    // leaves one unassigned; otherwise synthesis infers a latch.
    pwm_cnt_d    = pwm_cnt_q + PWM_W'(1);
    duty_d       = duty_q;
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    pending_d    = pending_q;
    cycle_done_d = 1'b0;
    pwm_out_d    = (pwm_cnt_q < duty_q);

    if (s4_pulse) begin
      // Restart abandons the profile; any coincident step_en is dropped.
      pwm_cnt_d  = '0;
      duty_d     = '0;
      state_d    = RISE;
      hold_cnt_d = '0;
      pending_d  = 1'b0;
    end else if (mode) begin
      pending_d = 1'b0;
    end else if (boundary) begin
      pending_d = 1'b0;
      if (pending_q || step_en) begin
        case (state_q)
          RISE: begin
            if (duty_q >= RISE_LIM) begin
              duty_d     = MAX_V;
              hold_cnt_d = '0;
              state_d    = HOLD_HI;
            end else begin
              duty_d = duty_q + STEP_V;
            end
          end
          HOLD_HI: begin
            if (hold_cnt_q == HOLD_LAST) begin
              hold_cnt_d = '0;
              state_d    = FALL;
            end else begin
              hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
          end
          FALL: begin
            if (duty_q <= STEP_V) begin
              duty_d     = '0;
              hold_cnt_d = '0;
              state_d    = HOLD_LO;
            end else begin
              duty_d = duty_q - STEP_V;
            end
          end
          default: begin
            if (hold_cnt_q == HOLD_LAST) begin
              hold_cnt_d   = '0;
              state_d      = RISE;
              cycle_done_d = 1'b1;
            end else begin
              hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
          end
        endcase
      end
    end else begin
      // Steps within a period collapse into one apply at the boundary.
      pending_d = pending_q | step_en;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q    <= '0;
      duty_q       <= '0;
      state_q      <= RISE;
      hold_cnt_q   <= '0;
      pending_q    <= 1'b0;
      pwm_out_q    <= 1'b0;
      cycle_done_q <= 1'b0;
    end else begin
      pwm_cnt_q    <= pwm_cnt_d;
      duty_q       <= duty_d;
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      pending_q    <= pending_d;
      pwm_out_q    <= pwm_out_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  assign pwm_out    = pwm_out_q;
  assign duty       = duty_q;
  assign state      = state_q;
  assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_breath_led_ctrl.sv
// Bench for breath_led_ctrl: two 4-bit instances (STEP=1 and STEP=6) driven
// in lockstep and compared against a profile-table reference model.
module tb_breath_led_ctrl;

  localparam int MAXV = 15;

  logic       clk = 1'b0;
  logic       rst, step_en, s4_pulse, mode;
  logic       pwm_a, pwm_b, cd_a, cd_b;
  logic [3:0] duty_a, duty_b;
  logic [1:0] state_a, state_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  breath_led_ctrl #(.PWM_W(4), .STEP(1), .HOLD_STEPS(2)) dut_a (
    .clk(clk), .rst(rst), .step_en(step_en), .s4_pulse(s4_pulse), .mode(mode),
    .pwm_out(pwm_a), .duty(duty_a), .state(state_a), .cycle_done(cd_a)
  );

  breath_led_ctrl #(.PWM_W(4), .STEP(6), .HOLD_STEPS(2)) dut_b (
    .clk(clk), .rst(rst), .step_en(step_en), .s4_pulse(s4_pulse), .mode(mode),
    .pwm_out(pwm_b), .duty(duty_b), .state(state_b), .cycle_done(cd_b)
  );

  // Reference model: the whole profile is a list of (duty,state) positions;
  // each applied step moves one position forward and wrapping means cycle_done.
  int prof_d[2][64];
  int prof_s[2][64];
  int plen[2];
  int m_cnt;
  bit m_pend;
  int m_pos[2];
  bit m_pwm[2];
  bit m_cd[2];
  int cd_seen[2];

  function automatic void build(int i, int step);
    int d = 0;
    int n = 0;
    do begin
      prof_d[i][n] = d; prof_s[i][n] = 0; n++;
      d = d + step; if (d > MAXV) d = MAXV;
    end while (d != MAXV);
    for (int k = 0; k < 2; k++) begin prof_d[i][n] = MAXV; prof_s[i][n] = 1; n++; end
    d = MAXV;
    do begin
      prof_d[i][n] = d; prof_s[i][n] = 2; n++;
      d = d - step; if (d < 0) d = 0;
    end while (d != 0);
    for (int k = 0; k < 2; k++) begin prof_d[i][n] = 0; prof_s[i][n] = 3; n++; end
    plen[i] = n;
  endfunction

  function automatic logic [7:0] exp_vec(int i);
    return {4'(prof_d[i][m_pos[i]]), 2'(prof_s[i][m_pos[i]]), m_pwm[i], m_cd[i]};
  endfunction

  function automatic logic [7:0] act_vec(int i);
    return (i == 0) ? {duty_a, state_a, pwm_a, cd_a} : {duty_b, state_b, pwm_b, cd_b};
  endfunction

  // One clock: model follows the inputs seen at the edge; outputs settle by negedge.
  task automatic cycle();
    bit np[2];
    @(posedge clk);
    for (int i = 0; i < 2; i++) np[i] = (m_cnt < prof_d[i][m_pos[i]]);
    if (rst) begin
      m_cnt = 0; m_pend = 0;
      for (int i = 0; i < 2; i++) begin m_pos[i] = 0; m_cd[i] = 0; m_pwm[i] = 0; end
    end else begin
      for (int i = 0; i < 2; i++) begin m_pwm[i] = np[i]; m_cd[i] = 0; end
      if (s4_pulse) begin
        m_cnt = 0; m_pend = 0;
        for (int i = 0; i < 2; i++) m_pos[i] = 0;
      end else begin
        if (mode) m_pend = 0;
        else if (m_cnt == MAXV) begin
          if (m_pend || step_en)
            for (int i = 0; i < 2; i++) begin
              m_pos[i] = (m_pos[i] + 1) % plen[i];
              if (m_pos[i] == 0) m_cd[i] = 1;
            end
          m_pend = 0;
        end else m_pend = m_pend | step_en;
        m_cnt = (m_cnt + 1) % (MAXV + 1);
      end
    end
    @(negedge clk);
    if (cd_a === 1'b1) cd_seen[0]++;
    if (cd_b === 1'b1) cd_seen[1]++;
  endtask

  task automatic idle_to(int c);
    for (int k = 0; k < 40 && m_cnt != c; k++) cycle();
  endtask

  task automatic do_step();
    idle_to(7);
    step_en = 1'b1; cycle(); step_en = 1'b0;
    idle_to(0);
  endtask

  task automatic restart();
    s4_pulse = 1'b1; cycle(); s4_pulse = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step_en = 1'($urandom_range(0, 1)); s4_pulse = 1'($urandom_range(0, 1));
      mode = 1'($urandom_range(0, 1));
      cycle();
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (act_vec(i) !== 8'h00) begin
        errors++; $display("FAIL reset dut%0d got=%h want=00", i, act_vec(i));
      end
    end
    checks++;
    if (dut_a.pwm_cnt_q !== 4'd0) begin
      errors++; $display("FAIL reset_cnt got=%0d want=0", dut_a.pwm_cnt_q);
    end
    rst = 1'b0; step_en = 1'b0; s4_pulse = 1'b0; mode = 1'b0;
  endtask

  task automatic test_ramp();
    int high = 0;
    restart();
    for (int s = 1; s <= 15; s++) begin
      do_step();
      checks++;
      if (duty_a !== 4'(s) || state_a !== ((s == 15) ? 2'd1 : 2'd0)) begin
        errors++; $display("FAIL ramp step%0d got duty=%0d st=%0d want duty=%0d", s, duty_a, state_a, s);
      end
      checks++;
      if (act_vec(0) !== exp_vec(0)) begin
        errors++; $display("FAIL ramp_model step%0d got=%h want=%h", s, act_vec(0), exp_vec(0));
      end
    end
    for (int k = 0; k < 16; k++) begin cycle(); high += int'(pwm_a); end
    checks++;
    if (high != 15) begin errors++; $display("FAIL ramp_pwm15 got=%0d want=15", high); end
  endtask

  task automatic test_full_profile();
    restart();
    cd_seen[0] = 0;
    for (int n = 1; n <= 68; n++) begin
      do_step();
      checks++;
      if (act_vec(0) !== exp_vec(0)) begin
        errors++; $display("FAIL profile step%0d got=%h want=%h", n, act_vec(0), exp_vec(0));
      end
      if (n == 17 || n == 32 || n == 34) begin
        checks++;
        if ({duty_a, state_a} !== ((n == 17) ? {4'd15, 2'd2} : (n == 32) ? {4'd0, 2'd3} : {4'd0, 2'd0})
            || (n == 34 && cd_seen[0] != 1)) begin
          errors++; $display("FAIL profile_mark step%0d got duty=%0d st=%0d cd=%0d", n, duty_a, state_a, cd_seen[0]);
        end
      end
    end
    checks++;
    if (cd_seen[0] != 2) begin errors++; $display("FAIL profile_cd got=%0d want=2", cd_seen[0]); end
  endtask

  task automatic test_collapse();
    restart();
    for (int k = 0; k < 3; k++) do_step();
    idle_to(1);
    for (int k = 0; k < 5; k++) begin
      step_en = 1'b1; cycle(); step_en = 1'b0; cycle();
    end
    idle_to(0);
    checks++;
    if (duty_a !== 4'd4) begin errors++; $display("FAIL collapse got=%0d want=4", duty_a); end
    idle_to(15);
    step_en = 1'b1; cycle(); step_en = 1'b0;
    checks++;
    if (duty_a !== 4'd5) begin errors++; $display("FAIL boundary_step got=%0d want=5", duty_a); end
    idle_to(15); cycle();
    checks++;
    if (duty_a !== 4'd5) begin errors++; $display("FAIL boundary_no_pend got=%0d want=5", duty_a); end
  endtask

  task automatic test_saturation();
    int wd[10] = '{6, 12, 15, 15, 15, 9, 3, 0, 0, 0};
    int ws[10] = '{0, 0, 1, 1, 2, 2, 2, 3, 3, 0};
    restart();
    cd_seen[1] = 0;
    for (int n = 0; n < 10; n++) begin
      do_step();
      checks++;
      if (duty_b !== 4'(wd[n]) || state_b !== 2'(ws[n])) begin
        errors++; $display("FAIL sat step%0d got duty=%0d st=%0d want duty=%0d st=%0d", n + 1, duty_b, state_b, wd[n], ws[n]);
      end
    end
    checks++;
    if (cd_seen[1] != 1) begin errors++; $display("FAIL sat_cd got=%0d want=1", cd_seen[1]); end
  endtask

  task automatic test_freeze();
    restart();
    for (int k = 0; k < 7; k++) do_step();
    mode = 1'b1;
    for (int p = 0; p < 10; p++) begin
      int high = 0;
      for (int k = 0; k < 16; k++) begin
        step_en = (k == 5); cycle(); step_en = 1'b0;
        high += int'(pwm_a);
      end
      checks++;
      if (duty_a !== 4'd7 || state_a !== 2'd0 || high != 7) begin
        errors++; $display("FAIL freeze p%0d got duty=%0d st=%0d high=%0d want 7/0/7", p, duty_a, state_a, high);
      end
    end
    mode = 1'b0;
    do_step();
    checks++;
    if (duty_a !== 4'd8) begin errors++; $display("FAIL unfreeze got=%0d want=8", duty_a); end
  endtask

  task automatic test_restart();
    for (int md = 0; md < 2; md++) begin
      mode = 1'b0;
      restart();
      for (int k = 0; k < 15; k++) do_step();
      mode = 1'(md);
      idle_to(5);
      cd_seen[0] = 0;
      s4_pulse = 1'b1; step_en = 1'b1; cycle(); s4_pulse = 1'b0; step_en = 1'b0;
      checks++;
      if (duty_a !== 4'd0 || state_a !== 2'd0 || dut_a.pwm_cnt_q !== 4'd0 || cd_a !== 1'b0) begin
        errors++; $display("FAIL restart m%0d got duty=%0d st=%0d cnt=%0d cd=%b", md, duty_a, state_a, dut_a.pwm_cnt_q, cd_a);
      end
      cycle();
      checks++;
      if (pwm_a !== 1'b0 || cd_seen[0] != 0) begin
        errors++; $display("FAIL restart_pwm m%0d got pwm=%b cd=%0d want 0/0", md, pwm_a, cd_seen[0]);
      end
    end
    mode = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 4000; k++) begin
      rst      = ($urandom_range(0, 499) == 0);
      s4_pulse = ($urandom_range(0, 199) == 0);
      step_en  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 299) == 0) mode = ~mode;
      cycle();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (act_vec(i) !== exp_vec(i)) begin
          errors++; $display("FAIL random dut%0d cyc%0d got=%h want=%h", i, k, act_vec(i), exp_vec(i));
        end
      end
    end
    rst = 1'b0; s4_pulse = 1'b0; step_en = 1'b0; mode = 1'b0;
  endtask

  initial begin
    rst = 1'b1; step_en = 1'b0; s4_pulse = 1'b0; mode = 1'b0;
    m_cnt = 0; m_pend = 0;
    for (int i = 0; i < 2; i++) begin m_pos[i] = 0; m_pwm[i] = 0; m_cd[i] = 0; cd_seen[i] = 0; end
    build(0, 1);
    build(1, 6);
    @(negedge clk);
    test_reset();
    test_ramp();
    test_full_profile();
    test_collapse();
    test_saturation();
    test_freeze();
    test_restart();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
